// File: rtl/shift_sequencer.sv
// Multi-cycle ARM operand-2 shifter: one 1-bit shift/rotate per cycle under an
// idle/shift/done FSM, with valid/ready on both sides and ARM carry-out semantics.
module shift_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [11:0]      in_src2,
    input  logic             in_i,
    input  logic             in_reg,
    input  logic [7:0]       in_rs,
    input  logic             in_carry,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);

    typedef enum logic [1:0] {st_idle, st_shift, st_done} state_e;
    typedef enum logic [1:0] {sh_lsl, sh_lsr, sh_asr, sh_ror} shift_e;

    // Logical shifts need one extra step past WIDTH so the carry also clears.
    localparam logic [31:0] SatLogic = 32'(WIDTH + 1);
    localparam logic [31:0] SatArith = 32'(WIDTH);

    state_e             state_q, state_d;
    shift_e             type_q, type_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    shift_e             req_type;
    logic [7:0]         req_amt;
    logic [WIDTH-1:0]   req_data;
    logic [CNT_W-1:0]   req_cnt;

    // Decode the request fields into operand, shift type and effective count.
    always_comb begin
        req_type = in_i ? sh_ror : shift_e'(in_src2[6:5]);
        req_data = in_i ? {{(WIDTH-8){1'b0}}, in_src2[7:0]} : in_data;
        if (in_i) begin
            req_amt = {3'b000, in_src2[11:8], 1'b0};
        end else if (in_reg) begin
            req_amt = in_rs;
        end else begin
            req_amt = {3'b000, in_src2[11:7]};
        end

        req_cnt = '0;
        case (req_type)
            sh_lsl, sh_lsr: begin
                req_cnt = (32'(req_amt) > SatLogic) ? CNT_W'(SatLogic) : CNT_W'(req_amt);
            end
            sh_asr: begin
                req_cnt = (32'(req_amt) > SatArith) ? CNT_W'(SatArith) : CNT_W'(req_amt);
            end
            default: begin
                if (req_amt[4:0] != 5'd0) begin
                    req_cnt = CNT_W'(req_amt[4:0]);
                end else if (req_amt != 8'd0) begin
                    req_cnt = CNT_W'(WIDTH);
                end else begin
                    req_cnt = '0;
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        data_d  = data_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;

        if (cancel) begin
            state_d = st_idle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                st_idle: begin
                    if (in_valid) begin
                        type_d  = req_type;
                        data_d  = req_data;
                        carry_d = in_carry;
                        cnt_d   = req_cnt;
                        state_d = (req_cnt != '0) ? st_shift : st_done;
                    end
                end
                st_shift: begin
                    case (type_q)
                        sh_lsl: begin
                            carry_d = data_q[WIDTH-1];
                            data_d  = {data_q[WIDTH-2:0], 1'b0};
                        end
                        sh_lsr: begin
                            carry_d = data_q[0];
                            data_d  = {1'b0, data_q[WIDTH-1:1]};
                        end
                        sh_asr: begin
                            carry_d = data_q[0];
                            data_d  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                        end
                        default: begin
                            carry_d = data_q[0];
                            data_d  = {data_q[0], data_q[WIDTH-1:1]};
                        end
                    endcase
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = st_done;
                    end
                end
                st_done: begin
                    if (out_ready) begin
                        state_d = st_idle;
                    end
                end
                default: begin
                    state_d = st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= st_idle;
            type_q  <= sh_lsl;
            data_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == st_idle);
    assign out_valid = (state_q == st_done);
    assign busy      = (state_q != st_idle);
    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic ARM shifter model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [11:0] in_src2;
    logic        in_i;
    logic        in_reg;
    logic [7:0]  in_rs;
    logic        in_carry;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        busy;

    int checks = 0;
    int failures = 0;

    shift_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_src2   (in_src2),
        .in_i      (in_i),
        .in_reg    (in_reg),
        .in_rs     (in_rs),
        .in_carry  (in_carry),
        .cancel    (cancel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ARM barrel-shifter result computed directly from the amount, plus the cycle count.
    task automatic model(input logic [31:0] d, input logic [11:0] s2, input logic i,
                         input logic r, input logic [7:0] rs, input logic cin,
                         output logic [31:0] res, output logic cout, output int lat);
        logic [31:0] op;
        int          a;
        int          t;
        int          k;
        op = i ? {24'd0, s2[7:0]} : d;
        t  = i ? 3 : int'(s2[6:5]);
        a  = i ? 2 * int'(s2[11:8]) : (r ? int'(rs) : int'(s2[11:7]));
        res = op;
        cout = cin;
        lat = 0;
        if (a != 0) begin
            case (t)
                0: begin
                    lat = (a > 33) ? 33 : a;
                    if (a < 32) begin res = op << a; cout = op[32 - a]; end
                    else if (a == 32) begin res = 0; cout = op[0]; end
                    else begin res = 0; cout = 1'b0; end
                end
                1: begin
                    lat = (a > 33) ? 33 : a;
                    if (a < 32) begin res = op >> a; cout = op[a - 1]; end
                    else if (a == 32) begin res = 0; cout = op[31]; end
                    else begin res = 0; cout = 1'b0; end
                end
                2: begin
                    lat = (a > 32) ? 32 : a;
                    if (a < 32) begin res = 32'($signed(op) >>> a); cout = op[a - 1]; end
                    else begin res = {32{op[31]}}; cout = op[31]; end
                end
                default: begin
                    k = a % 32;
                    lat = (k == 0) ? 32 : k;
                    if (k == 0) begin res = op; cout = op[31]; end
                    else begin res = (op >> k) | (op << (32 - k)); cout = op[k - 1]; end
                end
            endcase
        end
    endtask

    task automatic run_op(input logic [31:0] d, input logic [11:0] s2, input logic i,
                          input logic r, input logic [7:0] rs, input logic cin, input int hold);
        logic [31:0] exp_d;
        logic        exp_c;
        int          exp_lat;
        int          lat;
        model(d, s2, i, r, rs, cin, exp_d, exp_c, exp_lat);
        @(negedge clk);
        in_data = d; in_src2 = s2; in_i = i; in_reg = r; in_rs = rs; in_carry = cin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after accept; they must not matter any more.
        in_valid = 1'b0;
        in_data = $urandom; in_src2 = 12'($urandom); in_rs = 8'($urandom);
        in_i = 1'($urandom); in_reg = 1'($urandom); in_carry = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("out_data", 64'(out_data), 64'(exp_d));
        check("out_carry", 64'(out_carry), 64'(exp_c));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({out_carry, out_data}), 64'({exp_c, exp_d}));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_handshake", 64'({in_ready, busy, out_valid}), 64'b100);
    endtask

    initial begin
        logic [7:0]  rs;
        logic [11:0] s2;
        in_valid = 0; in_data = 0; in_src2 = 0; in_i = 0; in_reg = 0; in_rs = 0;
        in_carry = 0; cancel = 0; out_ready = 0;
        reset = 1'b1;
        #1;
        check("reset_state", 64'({in_ready, out_valid, busy, out_carry, out_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0}));
        #22;
        reset = 1'b0;

        run_op(32'h0000_0001, 12'h000, 1'b0, 1'b1, 8'd4,   1'b0, 0);
        run_op(32'h8000_0001, 12'h020, 1'b0, 1'b1, 8'd32,  1'b0, 0);
        run_op(32'h8000_0001, 12'h020, 1'b0, 1'b1, 8'd200, 1'b1, 0);
        run_op(32'h8000_0000, 12'h040, 1'b0, 1'b1, 8'd40,  1'b0, 0);
        run_op(32'h8000_0001, 12'h060, 1'b0, 1'b1, 8'd32,  1'b0, 0);
        run_op(32'h8000_0001, 12'h060, 1'b0, 1'b1, 8'd36,  1'b0, 0);
        run_op(32'h1234_5678, 12'h4FF, 1'b1, 1'b0, 8'd0,   1'b0, 0);
        run_op(32'h1234_5678, 12'h0AB, 1'b1, 1'b0, 8'd0,   1'b1, 0);
        run_op(32'hDEAD_BEEF, 12'h000, 1'b0, 1'b1, 8'd0,   1'b1, 0);
        run_op(32'h0000_0003, 12'h000, 1'b0, 1'b1, 8'd32,  1'b1, 0);
        run_op(32'hCAFE_F00D, 12'h0A5, 1'b0, 1'b0, 8'd0,   1'b1, 10);

        // Cancel mid-shift: back to idle on the next edge, out_valid never rises.
        @(negedge clk);
        in_data = 32'hFFFF_0000; in_src2 = 12'h000; in_i = 0; in_reg = 1; in_rs = 8'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        check("busy_before_cancel", 64'({busy, out_valid}), 64'b10);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_to_idle", 64'({in_ready, busy, out_valid}), 64'b100);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check("cancel_no_valid", 64'({busy, out_valid}), 64'b00);
        end

        // Cancel in idle blocks a simultaneous request.
        @(negedge clk);
        in_valid = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; cancel = 1'b0;
        check("cancel_blocks_accept", 64'({in_ready, busy}), 64'b10);

        // Async reset mid-shift clears outputs with no clock edge.
        @(negedge clk);
        in_data = 32'hA5A5_A5A5; in_src2 = 12'h000; in_reg = 1; in_rs = 8'd20; in_carry = 1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 64'({in_ready, busy, out_valid, out_carry, out_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd0}));
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 4))
                0: rs = 8'($urandom_range(0, 8));
                1: rs = 8'($urandom_range(28, 36));
                2: rs = 8'($urandom_range(60, 68));
                default: rs = 8'($urandom);
            endcase
            s2 = 12'($urandom);
            run_op($urandom, s2, 1'($urandom), 1'($urandom), rs, 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle operand-2 shift unit for the ARM datapath; handles register-specified shift amounts (Rs[7:0], 0-255) and immediate rotates with ARM carry-out semantics.
- Performs one 1-bit shift/rotate per cycle under an IDLE/SHIFT/DONE FSM.
- Valid/ready on input and output lets the controller stall the pipe while a long shift runs.
- Sits between the register file read ports and the ALU src2 mux.

Parameters:
- WIDTH, 32, datapath width; saturation thresholds scale with it.
- CNT_W, 6, shift-counter width; must hold WIDTH+1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; returns the block to IDLE.
- in_valid  input  1  request present.
- in_ready  output  1  high only in IDLE.
- in_data  input  WIDTH  Rm value (ignored when in_i=1).
- in_src2  input  12  instruction src2 field: rot[11:8]/imm8[7:0] or shamt5[11:7]/sh[6:5].
- in_i  input  1  1 = immediate rotate form.
- in_reg  input  1  1 = amount from in_rs (register shift); 0 = shamt5.
- in_rs  input  8  Rs[7:0].
- in_carry  input  1  current C flag.
- cancel  input  1  synchronous flush.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  shifter carry-out.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async): state=IDLE, out_valid=0, out_data=0, out_carry=0, busy=0, counter=0.
- Accept on the edge with in_valid && in_ready.
- At accept, latch the following:
  - Operand: in_i ? zero-extended imm8 : in_data. Shift type: in_i ? ROR : sh.
  - Raw amount A: in_i ? 2*rot; else in_reg ? in_rs : shamt5 (literal; shamt5=0 means no shift, no RRX).
  - Carry register = in_carry.
- Effective count C:
  - LSL/LSR: min(A, WIDTH+1).
  - ASR: min(A, WIDTH).
  - ROR: A[4:0] if A[4:0]!=0; WIDTH if A!=0 and A[4:0]==0; 0 if A==0.
- Next state after accept: SHIFT if C>0, else DONE.
- SHIFT, each edge:
  - Shift/rotate the result register by 1 and load the carry register with the bit shifted out.
  - LSL: out bit 31 (MSB), shift in 0. LSR: out bit 0, shift in 0. ASR: out bit 0, shift in MSB. ROR: out bit 0, MSB gets bit 0.
  - Decrement counter; when it reaches 0, go to DONE.
- Latency: accept at edge k gives out_valid high after edge k+C. C=0 gives DONE after edge k.
- Results match ARM semantics:
  - LSL 32: result 0, carry=data[0].
  - LSL/LSR >32: result 0, carry 0.
  - ASR ≥32: all sign bits, carry=sign.
  - ROR 32n: result unchanged, carry=data[31].
  - Amount 0: data unchanged, carry=in_carry.
  - Immediate rot=0: carry=in_carry.
- DONE: out_valid=1; out_data/out_carry stable until handshake. On out_ready, go to IDLE at that edge. No back-to-back accept: earliest new accept is the cycle after.
- out_data/out_carry keep their last value in IDLE; consumers qualify with out_valid.
- cancel has priority over all transitions: next state IDLE, out_valid=0, counter=0, data registers unchanged. A simultaneous in_valid is not accepted.
- Reset mid-SHIFT or in DONE discards the operation immediately.
- in_* are sampled only at accept; later changes have no effect.

Test Plan:
- LSL register shift: in_data=0x0000_0001, in_rs=4, in_reg=1, sh=00, in_carry=0 -> out_valid 4 cycles after accept; out_data=0x10, out_carry=0.
- LSR saturation: in_data=0x8000_0001, in_rs=32 -> out_data=0, carry=1. Repeat with in_rs=200 -> out_data=0, carry=0, latency 33 cycles.
- ASR/ROR edges:
  - ASR in_data=0x8000_0000, in_rs=40 -> 0xFFFF_FFFF, carry=1.
  - ROR in_data=0x8000_0001, in_rs=32 -> 0x8000_0001, carry=1.
  - ROR in_rs=36 -> 0x1800_0000, carry=0.
- Immediate rotate and zero amount:
  - in_i=1, src2=0x4FF -> out_data=0xFF00_0000, carry=1, 8 cycles.
  - src2=0x0AB, in_carry=1 -> 0xAB, carry=1, out_valid after edge k.
  - Register shift with in_rs=0 keeps in_carry.
- Backpressure: hold out_ready=0 10 cycles in DONE -> outputs stable, in_ready=0. Raise out_ready -> IDLE next edge; new request accepted the following cycle.
- Cancel/reset: assert cancel mid-SHIFT (rs=20, cycle 5) -> IDLE next edge, out_valid never rises. Assert async reset mid-SHIFT -> outputs zero immediately without a clock edge.
